// File: rtl/fcvt_pipe.sv
// fcvt_pipe: pipelined float32 <-> integer converter with RNE/RTZ rounding,
// saturation, invalid/inexact flags and a pass-through tag. Input register
// followed by three processing stages; fixed latency of 3 cycles.
module fcvt_pipe #(
    parameter int unsigned INT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv,
    output logic             out_nx
);

    localparam logic [31:0] SAT_POS = 32'((64'd1 << (INT_W - 1)) - 64'd1);
    localparam logic [31:0] SAT_NEG = ~SAT_POS;
    localparam logic [1:0]  OP_RTZ  = 2'b01;

    logic adv;

    // input register
    logic             v0_q;
    logic [1:0]       op0_q;
    logic [TAG_W-1:0] tag0_q;
    logic [31:0]      data0_q;

    // stage 1: classification / absolute value
    logic             v1_q, sign1_q, zero1_q, inf1_q, nan1_q;
    logic [1:0]       op1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [7:0]       exp1_q;
    logic [31:0]      mag1_q;
    logic             sign1_d, zero1_d, inf1_d, nan1_d;
    logic [7:0]       exp1_d;
    logic [31:0]      mag1_d, ival;

    // stage 2: normalisation / alignment
    logic             v2_q, sign2_q, g2_q, st2_q, big2_q, nan2_q, zero2_q;
    logic [1:0]       op2_q;
    logic [TAG_W-1:0] tag2_q;
    logic [7:0]       exp2_q;
    logic [31:0]      mag2_q;
    logic             g2_d, st2_d, big2_d;
    logic [7:0]       exp2_d;
    logic [31:0]      mag2_d, norm;
    logic [4:0]       lz;
    logic [63:0]      wide;

    // stage 3: rounding / saturation / flags (output registers)
    logic             out_valid_q, out_nv_q, out_nx_q;
    logic [31:0]      out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [31:0]      res_d;
    logic             nv_d, nx_d, rnd_up;
    logic [32:0]      sum, limit;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_nv    = out_nv_q;
    assign out_nx    = out_nx_q;

    // capture accepted operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q    <= 1'b0;
            op0_q   <= '0;
            tag0_q  <= '0;
            data0_q <= '0;
        end else if (adv) begin
            v0_q <= in_valid;
            if (in_valid) begin
                op0_q   <= in_op;
                tag0_q  <= in_tag;
                data0_q <= in_data;
            end
        end
    end

    // unpack float fields, or take |int| for itof
    always_comb begin
        sign1_d = 1'b0;
        exp1_d  = '0;
        mag1_d  = '0;
        zero1_d = 1'b0;
        inf1_d  = 1'b0;
        nan1_d  = 1'b0;
        ival    = '0;
        if (op0_q[1]) begin
            ival    = op0_q[0] ? 32'(data0_q[INT_W-1:0])
                               : 32'($signed(data0_q[INT_W-1:0]));
            sign1_d = ~op0_q[0] & ival[31];
            mag1_d  = sign1_d ? (~ival + 32'd1) : ival;
            zero1_d = (ival == '0);
        end else begin
            sign1_d = data0_q[31];
            exp1_d  = data0_q[30:23];
            mag1_d  = {8'd0, (data0_q[30:23] != 8'd0), data0_q[22:0]};
            zero1_d = (data0_q[30:23] == 8'd0);
            inf1_d  = (data0_q[30:23] == 8'hFF) & (data0_q[22:0] == '0);
            nan1_d  = (data0_q[30:23] == 8'hFF) & (data0_q[22:0] != '0);
        end
    end

    // stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            op1_q   <= '0;
            tag1_q  <= '0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            mag1_q  <= '0;
            zero1_q <= 1'b0;
            inf1_q  <= 1'b0;
            nan1_q  <= 1'b0;
        end else if (adv) begin
            v1_q <= v0_q;
            if (v0_q) begin
                op1_q   <= op0_q;
                tag1_q  <= tag0_q;
                sign1_q <= sign1_d;
                exp1_q  <= exp1_d;
                mag1_q  <= mag1_d;
                zero1_q <= zero1_d;
                inf1_q  <= inf1_d;
                nan1_q  <= nan1_d;
            end
        end
    end

    // itof: leading-one normalise; ftoi: align integer part, extract guard/sticky
    always_comb begin
        mag2_d = '0;
        exp2_d = '0;
        g2_d   = 1'b0;
        st2_d  = 1'b0;
        big2_d = 1'b0;
        lz     = '0;
        norm   = '0;
        wide   = '0;
        if (op1_q[1]) begin
            for (int i = 0; i < 32; i++) begin
                if (mag1_q[i]) lz = 5'(31 - i);
            end
            norm   = mag1_q << lz;
            mag2_d = {8'd0, norm[31:8]};
            g2_d   = norm[7];
            st2_d  = |norm[6:0];
            exp2_d = 8'(9'd158 - 9'(lz));
        end else if (inf1_q || (exp1_q > 8'd158)) begin
            big2_d = 1'b1;
        end else if (zero1_q) begin
            // denormals sit far below one half: sticky only
            st2_d = |mag1_q;
        end else if (exp1_q < 8'd127) begin
            g2_d  = (exp1_q == 8'd126);
            st2_d = (exp1_q != 8'd126) | (|mag1_q[22:0]);
        end else begin
            wide   = {mag1_q[23:0], 40'd0} >> (8'd158 - exp1_q);
            mag2_d = wide[63:32];
            g2_d   = wide[31];
            st2_d  = |wide[30:0];
        end
    end

    // stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            op2_q   <= '0;
            tag2_q  <= '0;
            sign2_q <= 1'b0;
            exp2_q  <= '0;
            mag2_q  <= '0;
            g2_q    <= 1'b0;
            st2_q   <= 1'b0;
            big2_q  <= 1'b0;
            nan2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                op2_q   <= op1_q;
                tag2_q  <= tag1_q;
                sign2_q <= sign1_q;
                exp2_q  <= exp2_d;
                mag2_q  <= mag2_d;
                g2_q    <= g2_d;
                st2_q   <= st2_d;
                big2_q  <= big2_d;
                nan2_q  <= nan1_q;
                zero2_q <= zero1_q;
            end
        end
    end

    // round, saturate, apply sign, raise flags
    always_comb begin
        res_d  = '0;
        nv_d   = 1'b0;
        nx_d   = 1'b0;
        rnd_up = (op2_q != OP_RTZ) & g2_q & (st2_q | mag2_q[0]);
        sum    = {1'b0, mag2_q} + 33'(rnd_up);
        limit  = {1'b0, SAT_POS} + 33'(sign2_q);
        if (op2_q[1]) begin
            if (!zero2_q) begin
                nx_d = g2_q | st2_q;
                if (sum[24]) res_d = {sign2_q, exp2_q + 8'd1, 23'd0};
                else         res_d = {sign2_q, exp2_q, sum[22:0]};
            end
        end else if (nan2_q) begin
            res_d = SAT_POS;
            nv_d  = 1'b1;
        end else if (big2_q || (sum > limit)) begin
            res_d = sign2_q ? SAT_NEG : SAT_POS;
            nv_d  = 1'b1;
        end else begin
            res_d = sign2_q ? (~sum[31:0] + 32'd1) : sum[31:0];
            nx_d  = g2_q | st2_q;
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_nv_q    <= 1'b0;
            out_nx_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_data_q <= res_d;
                out_tag_q  <= tag2_q;
                out_nv_q   <= nv_d;
                out_nx_q   <= nx_d;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_pipe.sv
// Bench for fcvt_pipe: directed vector table, back-pressure and random
// streams against an arithmetic reference model, and mid-stream reset.
module tb_fcvt_pipe;

    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic [1:0] in_op;
    logic [31:0] in_data;
    logic [TAG_W-1:0] in_tag;

    logic in_ready32, out_valid32, nv32, nx32;
    logic [31:0] od32;
    logic [TAG_W-1:0] ot32;
    logic in_ready16, out_valid16, nv16, nx16;
    logic [31:0] od16;
    logic [TAG_W-1:0] ot16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fcvt_pipe #(.INT_W(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_op(in_op), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(od32),
        .out_tag(ot32), .out_nv(nv32), .out_nx(nx32));

    fcvt_pipe #(.INT_W(16), .TAG_W(TAG_W)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_op(in_op), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(od16),
        .out_tag(ot16), .out_nv(nv16), .out_nx(nx16));

    typedef struct packed {
        logic [31:0] data;
        logic        nv;
        logic        nx;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic        w16;
        logic [31:0] exp_data;
        logic        exp_nv;
        logic        exp_nx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact arithmetic on the numeric value: quotient/remainder against 2^k.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] d, input int w);
        res_t r;
        longint maxp, minn, mant, q, rem, half, v, mag, mask;
        int ex, e, sh, p;
        logic ovf, sgn;
        r = '0;
        maxp = (longint'(1) << (w - 1)) - 1;
        minn = -(longint'(1) << (w - 1));
        ovf = 1'b0;
        rem = 0;
        half = 1;
        q = 0;
        if (!op[1]) begin
            ex = int'(d[30:23]);
            if (ex == 255) begin
                r.nv = 1'b1;
                r.data = (d[22:0] != 0 || !d[31]) ? 32'(maxp) : 32'(minn);
                return r;
            end
            mant = (ex == 0) ? longint'(d[22:0]) : longint'({1'b1, d[22:0]});
            e = (ex == 0) ? -126 : ex - 127;
            if (e > 40) ovf = 1'b1;
            else if (e >= 23) q = mant << (e - 23);
            else begin
                sh = 23 - e;
                if (sh > 62) sh = 62;
                q = mant >> sh;
                rem = mant - (q << sh);
                half = longint'(1) << (sh - 1);
            end
            if (op == 2'b00 && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
            v = d[31] ? -q : q;
            if (ovf || v > maxp || v < minn) begin
                r.nv = 1'b1;
                r.data = d[31] ? 32'(minn) : 32'(maxp);
            end else begin
                r.data = 32'(v);
                r.nx = (rem != 0);
            end
        end else begin
            mask = (longint'(1) << w) - 1;
            v = longint'(d) & mask;
            if (!op[0] && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
            sgn = (v < 0);
            mag = sgn ? -v : v;
            if (mag == 0) return r;
            p = 0;
            for (int i = 0; i < 63; i++) if (((mag >> i) & 64'd1) != 0) p = i;
            if (p <= 23) q = mag << (23 - p);
            else begin
                sh = p - 23;
                q = mag >> sh;
                rem = mag - (q << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
                if (q == (longint'(1) << 24)) begin
                    q = q >> 1;
                    p = p + 1;
                end
            end
            r.data = {sgn, 8'(p + 127), 23'(q)};
            r.nx = (rem != 0);
        end
        return r;
    endfunction

    function automatic void add(input logic [1:0] op, input logic [31:0] d, input logic w16,
                                input logic [31:0] ed, input logic env, input logic enx);
        vec_t v;
        v.op = op; v.data = d; v.w16 = w16;
        v.exp_data = ed; v.exp_nv = env; v.exp_nx = enx;
        vecs.push_back(v);
    endfunction

    // One isolated operation: checks fixed latency, result, flags and tag.
    task automatic run_vec(input vec_t v, input int idx);
        int cnt;
        logic ov;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = v.op; in_data = v.data; in_tag = TAG_W'(idx);
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom; in_op = 2'($urandom_range(0, 3));
        cnt = 0;
        ov = v.w16 ? out_valid16 : out_valid32;
        while (!ov && cnt < 10) begin
            @(negedge clk);
            cnt++;
            ov = v.w16 ? out_valid16 : out_valid32;
        end
        check($sformatf("vec%0d_latency", idx), 32'(cnt), 32'd3);
        check($sformatf("vec%0d_data", idx), v.w16 ? od16 : od32, v.exp_data);
        check($sformatf("vec%0d_nv", idx), 32'(v.w16 ? nv16 : nv32), 32'(v.exp_nv));
        check($sformatf("vec%0d_nx", idx), 32'(v.w16 ? nx16 : nx32), 32'(v.exp_nx));
        check($sformatf("vec%0d_tag", idx), 32'(v.w16 ? ot16 : ot32), 32'(idx));
    endtask

    task automatic gen(output logic [1:0] op, output logic [31:0] d);
        op = 2'($urandom_range(0, 3));
        d = $urandom;
        if (!op[1] && $urandom_range(0, 3) != 0) d[30:23] = 8'($urandom_range(110, 165));
        if (op[1] && $urandom_range(0, 1) == 1) d = d >> $urandom_range(0, 31);
    endtask

    // Streams n ops; mode 0: always offer, out_ready toggles 1,0,...; mode 1: random both.
    task automatic stream(input int n, input int mode);
        res_t q32[$], q16[$];
        logic [TAG_W-1:0] tq[$];
        res_t e32, e16;
        logic [TAG_W-1:0] et, ht;
        logic [31:0] hd, nd;
        logic [1:0] nop;
        logic held;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0; hd = '0; ht = '0;
        gen(nop, nd);
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = (mode == 0) ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
            if (sent < n && (mode == 0 || $urandom_range(0, 4) != 0)) begin
                in_valid = 1'b1; in_op = nop; in_data = nd; in_tag = TAG_W'(sent);
            end else begin
                in_valid = 1'b0; in_data = $urandom;
            end
            #1;
            check("in_ready", 32'(in_ready32), 32'(!(out_valid32 && !out_ready)));
            if (held) begin
                check("stall_data", od32, hd);
                check("stall_tag", 32'(ot32), 32'(ht));
            end
            held = out_valid32 && !out_ready;
            hd = od32; ht = ot32;
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_extra: unexpected result tag %0d", ot32);
                end else begin
                    e32 = q32.pop_front(); e16 = q16.pop_front(); et = tq.pop_front();
                    check($sformatf("s%0d_data32", got), od32, e32.data);
                    check($sformatf("s%0d_nv32", got), 32'(nv32), 32'(e32.nv));
                    check($sformatf("s%0d_nx32", got), 32'(nx32), 32'(e32.nx));
                    check($sformatf("s%0d_tag", got), 32'(ot32), 32'(et));
                    check($sformatf("s%0d_valid16", got), 32'(out_valid16), 32'd1);
                    check($sformatf("s%0d_data16", got), od16, e16.data);
                    check($sformatf("s%0d_nv16", got), 32'(nv16), 32'(e16.nv));
                    check($sformatf("s%0d_nx16", got), 32'(nx16), 32'(e16.nx));
                end
                got++;
            end
            if (in_valid && in_ready32) begin
                q32.push_back(model(nop, nd, 32));
                q16.push_back(model(nop, nd, 16));
                tq.push_back(TAG_W'(sent));
                sent++;
                gen(nop, nd);
            end
        end
        check($sformatf("stream_mode%0d_count", mode), 32'(got), 32'(n));
        check($sformatf("stream_mode%0d_leftover", mode), 32'(q32.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int stale;
        vec_t rv;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_data = '0; in_tag = '0;

        add(2'b00, 32'h40200000, 0, 32'h00000002, 0, 1);
        add(2'b00, 32'h40600000, 0, 32'h00000004, 0, 1);
        add(2'b01, 32'hC02CCCCD, 0, 32'hFFFFFFFE, 0, 1);
        add(2'b00, 32'h3F000000, 0, 32'h00000000, 0, 1);
        add(2'b00, 32'h4F000000, 0, 32'h7FFFFFFF, 1, 0);
        add(2'b00, 32'hCF000000, 0, 32'h80000000, 0, 0);
        add(2'b00, 32'h7FC00000, 0, 32'h7FFFFFFF, 1, 0);
        add(2'b00, 32'hFF800000, 0, 32'h80000000, 1, 0);
        add(2'b10, 32'h80000000, 0, 32'hCF000000, 0, 0);
        add(2'b10, 32'h01000001, 0, 32'h4B800000, 0, 1);
        add(2'b11, 32'hFFFFFFFF, 0, 32'h4F800000, 0, 1);
        add(2'b10, 32'h00000000, 0, 32'h00000000, 0, 0);
        add(2'b00, 32'h3F400000, 0, 32'h00000001, 0, 1);
        add(2'b00, 32'hBF400000, 0, 32'hFFFFFFFF, 0, 1);
        add(2'b01, 32'h3F7FFFFF, 0, 32'h00000000, 0, 1);
        add(2'b00, 32'h00000001, 0, 32'h00000000, 0, 1);
        add(2'b11, 32'h00000001, 0, 32'h3F800000, 0, 0);
        add(2'b00, 32'h471C4000, 1, 32'h00007FFF, 1, 0);
        add(2'b10, 32'h00008000, 1, 32'hC7000000, 0, 0);
        add(2'b00, 32'hC7000000, 1, 32'hFFFF8000, 0, 0);
        add(2'b00, 32'hC7000080, 1, 32'hFFFF8000, 0, 1);
        add(2'b01, 32'h46FFFE00, 1, 32'h00007FFF, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid32), 32'd0);
        check("rst_out_data", od32, 32'd0);
        check("rst_out_tag", 32'(ot32), 32'd0);
        check("rst_flags", 32'({nv32, nx32}), 32'd0);
        check("rst_in_ready", 32'(in_ready32), 32'd1);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        stream(16, 0);
        stream(300, 1);

        // reset with operations in flight, asserted between clock edges
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_op = 2'b10; in_data = 32'(k + 7); in_tag = TAG_W'(k + 20);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid32), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid32), 32'd0);
        check("mid_rst_out_data", od32, 32'd0);
        check("mid_rst_out_tag", 32'(ot32), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready32), 32'd1);
        #1 rst = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid32 || out_valid16) stale++;
        end
        check("post_rst_stale", 32'(stale), 32'd0);
        rv.op = 2'b10; rv.data = 32'd5; rv.w16 = 1'b0;
        rv.exp_data = 32'h40A00000; rv.exp_nv = 1'b0; rv.exp_nx = 1'b0;
        run_vec(rv, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
